// File: rtl/fir_stream_adapter.sv
// fir_stream_adapter: AXI-Stream front/back end for the FIR datapath.
// Input samples are queued in a small FIFO, issued one at a time to the
// datapath (x_data_valid, then compute), and each result is returned on an
// AXI-Stream master port carrying the tlast of its originating sample.
module fir_stream_adapter #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [DATA_WIDTH-1:0]         x_data,
    output logic                          x_data_valid,
    output logic                          compute,
    input  logic [DATA_WIDTH-1:0]         output_data,
    input  logic                          output_data_valid,
    input  logic                          coefficient_loading_complete,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    // FIFO storage: each entry is {tlast, tdata}
    logic [EW-1:0]         mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;

    state_t                state_r;
    logic [TW-1:0]         timer_r;
    logic                  tlast_r;
    logic [DATA_WIDTH-1:0] x_data_r;
    logic                  x_data_valid_r;
    logic                  compute_r;
    logic [DATA_WIDTH-1:0] m_tdata_r;
    logic                  m_tvalid_r;
    logic                  m_tlast_r;
    logic                  timeout_err_r;

    logic                  full_s;
    logic                  flush_now_s;
    logic                  push_s;
    logic                  out_free_s;
    logic                  start_s;
    logic [EW-1:0]         rd_entry_s;

    // Handshake and issue qualification; flush wins over push and issue
    always_comb begin
        full_s      = (count_r == FULL_COUNT);
        flush_now_s = flush && (state_r == ST_IDLE);
        push_s      = s_axis_tvalid && !full_s && !flush_now_s;
        out_free_s  = !m_tvalid_r || m_axis_tready;
        start_s     = (state_r == ST_IDLE) && enable && coefficient_loading_complete &&
                      (count_r != {CW{1'b0}}) && out_free_s && !flush_now_s;
        rd_entry_s  = mem_r[rd_ptr_r];
    end

    // FIFO storage write; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush_now_s) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (start_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, start_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue/compute/wait sequencer with registered strobes and output register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r        <= ST_IDLE;
            timer_r        <= {TW{1'b0}};
            tlast_r        <= 1'b0;
            x_data_r       <= {DATA_WIDTH{1'b0}};
            x_data_valid_r <= 1'b0;
            compute_r      <= 1'b0;
            m_tdata_r      <= {DATA_WIDTH{1'b0}};
            m_tvalid_r     <= 1'b0;
            m_tlast_r      <= 1'b0;
            timeout_err_r  <= 1'b0;
        end else begin
            // Drain first; a capture later in this block overrides it
            if (m_tvalid_r && m_axis_tready) begin
                m_tvalid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (flush_now_s) begin
                        timeout_err_r <= 1'b0;
                    end else if (start_s) begin
                        state_r        <= ST_ISSUE;
                        x_data_r       <= rd_entry_s[DATA_WIDTH-1:0];
                        tlast_r        <= rd_entry_s[DATA_WIDTH];
                        x_data_valid_r <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_r        <= ST_COMPUTE;
                    x_data_valid_r <= 1'b0;
                    compute_r      <= 1'b1;
                end
                ST_COMPUTE: begin
                    state_r   <= ST_WAIT;
                    compute_r <= 1'b0;
                    timer_r   <= {TW{1'b0}};
                end
                ST_WAIT: begin
                    if (output_data_valid) begin
                        m_tdata_r  <= output_data;
                        m_tlast_r  <= tlast_r;
                        m_tvalid_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else if (timer_r == TIMER_LAST) begin
                        timeout_err_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    x_data_valid_r <= 1'b0;
                    compute_r      <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = !full_s;
    assign fifo_count    = count_r;
    assign busy          = (state_r != ST_IDLE);
    assign timeout_err   = timeout_err_r;
    assign x_data        = x_data_r;
    assign x_data_valid  = x_data_valid_r;
    assign compute       = compute_r;
    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign m_axis_tlast  = m_tlast_r;

endmodule
